regfile_wb_arbiter: RTL and testbench

- Shares the single write port of register_file (rd_addr_i / wr_en_i / wr_data_i) between two writeback sources: ALU/execute and LSU/load.
- Fixed LSU priority with an anti-starvation counter that forces an ALU grant after MAX_WAIT consecutive ALU losses.
- Write port output is registered (one-cycle latency). Writes to x0 are absorbed without consuming the port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_starve_counter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 64;
    localparam int CNT_W      = 4;

    // One writeback request as seen by the register file write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_LSU
    } wb_grant_e;

    // x0 is hardwired to zero, so writes to it never need the port.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the ALU writeback was denied.
module wb_starve_counter #(
    parameter int MAX_WAIT = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   inc,
    input  logic                                   clr,
    output logic [regfile_wb_arbiter_pkg::CNT_W-1:0] count,
    output logic                                   at_max
);
    import regfile_wb_arbiter_pkg::*;

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Clear wins over increment; increment stops at MAX_VAL.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != MAX_VAL)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == MAX_VAL);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter in front of the register file write port.
// LSU has fixed priority; the ALU is forced through after MAX_WAIT losses.
// x0 writes are accepted immediately and never occupy the port.
module regfile_wb_arbiter #(
    parameter int XLEN     = regfile_wb_arbiter_pkg::XLEN,
    parameter int MAX_WAIT = 3
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        alu_valid_i,
    input  logic [regfile_wb_arbiter_pkg::REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]                             alu_data_i,
    output logic                                        alu_ready_o,
    input  logic                                        lsu_valid_i,
    input  logic [regfile_wb_arbiter_pkg::REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]                             lsu_data_i,
    output logic                                        lsu_ready_o,
    output logic [regfile_wb_arbiter_pkg::REG_ADDR_W-1:0] rd_addr_o,
    output logic                                        wr_en_o,
    output logic [XLEN-1:0]                             wr_data_o,
    output logic [regfile_wb_arbiter_pkg::CNT_W-1:0]    starve_cnt_o
);
    import regfile_wb_arbiter_pkg::*;

    logic                  alu_x0;
    logic                  lsu_x0;
    logic                  alu_nz;
    logic                  lsu_nz;
    logic                  at_max;
    logic                  starve_inc;
    logic                  starve_clr;
    logic [CNT_W-1:0]      starve_cnt;
    wb_grant_e             grant;

    logic                  wr_en_reg;
    logic                  wr_en_next;
    logic [REG_ADDR_W-1:0] rd_addr_reg;
    logic [REG_ADDR_W-1:0] rd_addr_next;
    logic [XLEN-1:0]       wr_data_reg;
    logic [XLEN-1:0]       wr_data_next;

    wb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .count  (starve_cnt),
        .at_max (at_max)
    );

    // Classify requests, pick the port owner and drive the handshakes.
    always_comb begin
        alu_x0 = alu_valid_i && is_x0(alu_rd_i);
        lsu_x0 = lsu_valid_i && is_x0(lsu_rd_i);
        alu_nz = alu_valid_i && !is_x0(alu_rd_i);
        lsu_nz = lsu_valid_i && !is_x0(lsu_rd_i);

        grant = GRANT_NONE;
        if (!reset) begin
            if (alu_nz && (!lsu_nz || at_max)) begin
                grant = GRANT_ALU;
            end else if (lsu_nz) begin
                grant = GRANT_LSU;
            end
        end

        alu_ready_o = !reset && (alu_x0 || (grant == GRANT_ALU));
        lsu_ready_o = !reset && (lsu_x0 || (grant == GRANT_LSU));

        // Any cycle the ALU is not a losing non-x0 requester resets the wait.
        starve_inc = !reset && alu_nz && (grant != GRANT_ALU);
        starve_clr = !starve_inc;
    end

    // Next value of the write port; address/data hold when idle.
    always_comb begin
        wr_en_next   = 1'b0;
        rd_addr_next = rd_addr_reg;
        wr_data_next = wr_data_reg;
        case (grant)
            GRANT_ALU: begin
                wr_en_next   = 1'b1;
                rd_addr_next = alu_rd_i;
                wr_data_next = alu_data_i;
            end
            GRANT_LSU: begin
                wr_en_next   = 1'b1;
                rd_addr_next = lsu_rd_i;
                wr_data_next = lsu_data_i;
            end
            default: ;
        endcase
    end

    // Registered write port; reset drops any write still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg   <= wr_en_next;
            rd_addr_reg <= rd_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign wr_en_o      = wr_en_reg;
    assign rd_addr_o    = rd_addr_reg;
    assign wr_data_o    = wr_data_reg;
    assign starve_cnt_o = starve_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int XLEN     = 64;
    localparam int MAX_WAIT = 3;

    logic            clk;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready_o;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready_o;
    logic [4:0]      rd_addr_o;
    logic            wr_en_o;
    logic [XLEN-1:0] wr_data_o;
    logic [3:0]      starve_cnt_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    int              m_cnt;
    logic            exp_en;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
    logic [XLEN-1:0] exp_rf [32];

    // Simple register file fed by the DUT write port (ignores writes in reset).
    logic [XLEN-1:0] rf [32];

    regfile_wb_arbiter #(
        .XLEN     (XLEN),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid_i  (alu_valid),
        .alu_rd_i     (alu_rd),
        .alu_data_i   (alu_data),
        .alu_ready_o  (alu_ready_o),
        .lsu_valid_i  (lsu_valid),
        .lsu_rd_i     (lsu_rd),
        .lsu_data_i   (lsu_data),
        .lsu_ready_o  (lsu_ready_o),
        .rd_addr_o    (rd_addr_o),
        .wr_en_o      (wr_en_o),
        .wr_data_o    (wr_data_o),
        .starve_cnt_o (starve_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && wr_en_o) rf[rd_addr_o] <= wr_data_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: is the ALU request accepted this cycle?
    function automatic logic m_alu_acc();
        if (reset || !alu_valid) return 1'b0;
        if (alu_rd == 5'd0) return 1'b1;
        if (!(lsu_valid && lsu_rd != 5'd0)) return 1'b1;
        return (m_cnt == MAX_WAIT);
    endfunction

    // Model: is the LSU request accepted this cycle?
    function automatic logic m_lsu_acc();
        if (reset || !lsu_valid) return 1'b0;
        if (lsu_rd == 5'd0) return 1'b1;
        if (alu_valid && alu_rd != 5'd0 && m_cnt == MAX_WAIT) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock and the model with it; prints one line per write.
    task automatic tick();
        logic aa;
        logic la;
        aa = m_alu_acc();
        la = m_lsu_acc();
        @(posedge clk);
        if (!reset && exp_en) exp_rf[exp_rd] = exp_data;
        if (reset) begin
            m_cnt    = 0;
            exp_en   = 1'b0;
            exp_rd   = '0;
            exp_data = '0;
        end else begin
            exp_en = 1'b0;
            if (aa && alu_rd != 5'd0) begin
                exp_en = 1'b1; exp_rd = alu_rd; exp_data = alu_data;
                $display("txn t=%0t ALU wb rd=%0d data=%h", $time, alu_rd, alu_data);
            end
            if (la && lsu_rd != 5'd0) begin
                exp_en = 1'b1; exp_rd = lsu_rd; exp_data = lsu_data;
                $display("txn t=%0t LSU wb rd=%0d data=%h", $time, lsu_rd, lsu_data);
            end
            if (alu_valid && alu_rd != 5'd0 && !aa)
                m_cnt = (m_cnt < MAX_WAIT) ? m_cnt + 1 : MAX_WAIT;
            else
                m_cnt = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h55;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 64'h66;
        tick();
        tick();
        #2;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en_o); end
        checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr_o); end
        checks++; if (wr_data_o !== 64'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data_o); end
        checks++; if (starve_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_starve: got %0d expected 0", starve_cnt_o); end
        checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", alu_ready_o); end
        checks++; if (lsu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %b expected 0", lsu_ready_o); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
        #2;
        checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL alu_only_ready: got %b expected 1", alu_ready_o); end
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL alu_only_early_wr: got %b expected 0", wr_en_o); end
        tick();
        alu_valid = 1'b0;
        #2;
        checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL alu_only_wr_en: got %b expected 1", wr_en_o); end
        checks++; if (rd_addr_o !== 5'd5) begin errors++; $display("FAIL alu_only_rd: got %0d expected 5", rd_addr_o); end
        checks++; if (wr_data_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL alu_only_data: got %h expected deadbeef", wr_data_o); end
        tick();
        #2;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL alu_only_wr_off: got %b expected 0", wr_en_o); end
        checks++; if (rd_addr_o !== 5'd5) begin errors++; $display("FAIL alu_only_rd_hold: got %0d expected 5", rd_addr_o); end
        checks++; if (rf[5] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL alu_only_rf_x5: got %h expected deadbeef", rf[5]); end
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA3;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'hB4;
        for (int i = 0; i <= MAX_WAIT; i++) begin
            #2;
            checks++; if (starve_cnt_o !== 4'(i)) begin errors++; $display("FAIL starve_cnt[%0d]: got %0d expected %0d", i, starve_cnt_o, i); end
            checks++; if (alu_ready_o !== (i == MAX_WAIT)) begin errors++; $display("FAIL starve_alu_ready[%0d]: got %b expected %b", i, alu_ready_o, (i == MAX_WAIT)); end
            checks++; if (lsu_ready_o !== (i != MAX_WAIT)) begin errors++; $display("FAIL starve_lsu_ready[%0d]: got %b expected %b", i, lsu_ready_o, (i != MAX_WAIT)); end
            tick();
            #2;
            checks++; if (rd_addr_o !== ((i == MAX_WAIT) ? 5'd3 : 5'd4)) begin errors++; $display("FAIL starve_wr_rd[%0d]: got %0d expected %0d", i, rd_addr_o, (i == MAX_WAIT) ? 3 : 4); end
        end
        checks++; if (starve_cnt_o !== 4'd0) begin errors++; $display("FAIL starve_cnt_after_force: got %0d expected 0", starve_cnt_o); end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_mix();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
        #2;
        checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL x0_mix_alu_ready: got %b expected 1", alu_ready_o); end
        checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL x0_mix_lsu_ready: got %b expected 1", lsu_ready_o); end
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #2;
        checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL x0_mix_wr_en: got %b expected 1", wr_en_o); end
        checks++; if (rd_addr_o !== 5'd7) begin errors++; $display("FAIL x0_mix_rd: got %0d expected 7", rd_addr_o); end
        checks++; if (wr_data_o !== 64'h77) begin errors++; $display("FAIL x0_mix_data: got %h expected 77", wr_data_o); end
        checks++; if (starve_cnt_o !== 4'd0) begin errors++; $display("FAIL x0_mix_starve: got %0d expected 0", starve_cnt_o); end
        tick();
        #2;
        checks++; if (rf[7] !== 64'h77) begin errors++; $display("FAIL x0_mix_rf_x7: got %h expected 77", rf[7]); end
        checks++; if (rf[0] !== 64'h0) begin errors++; $display("FAIL x0_mix_rf_x0: got %h expected 0", rf[0]); end
    endtask

    task automatic test_lsu_x0();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hCAFE;
        #2;
        checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL lsu_x0_ready: got %b expected 1", lsu_ready_o); end
        tick();
        lsu_valid = 1'b0;
        #2;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL lsu_x0_wr_en: got %b expected 0", wr_en_o); end
        tick();
    endtask

    task automatic test_reset_pending();
        logic [XLEN-1:0] x9_before;
        x9_before = rf[9];
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h9999;
        #2;
        checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL rst_pend_ready: got %b expected 1", alu_ready_o); end
        tick();
        alu_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_pend_wr_en: got %b expected 0", wr_en_o); end
        checks++; if (starve_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_pend_starve: got %0d expected 0", starve_cnt_o); end
        checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL rst_pend_rd: got %0d expected 0", rd_addr_o); end
        tick();
        #2;
        checks++; if (rf[9] !== x9_before) begin errors++; $display("FAIL rst_pend_rf_x9: got %h expected %h", rf[9], x9_before); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 64'(1000 + i);
            #2;
            checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, lsu_ready_o); end
            if (i > 0) begin
                checks++; if (wr_en_o !== 1'b1 || rd_addr_o !== 5'(9 + i)) begin errors++; $display("FAIL b2b_wr[%0d]: got en=%b rd=%0d expected en=1 rd=%0d", i, wr_en_o, rd_addr_o, 9 + i); end
            end
            tick();
        end
        lsu_valid = 1'b0;
        #2;
        checks++; if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd13 || wr_data_o !== 64'd1003) begin errors++; $display("FAIL b2b_last: got en=%b rd=%0d data=%0d expected en=1 rd=13 data=1003", wr_en_o, rd_addr_o, wr_data_o); end
        tick();
        #2;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", wr_en_o); end
    endtask

    task automatic test_random();
        logic aa;
        logic la;
        aa = 1'b1;
        la = 1'b1;
        for (int n = 0; n < 400; n++) begin
            // Requesters keep a request stable until it is accepted.
            if (!alu_valid || aa) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = {$urandom, $urandom};
            end
            if (!lsu_valid || la) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 59) == 0);
            #2;
            checks++; if (alu_ready_o !== m_alu_acc()) begin errors++; $display("FAIL rnd_alu_ready[%0d]: got %b expected %b", n, alu_ready_o, m_alu_acc()); end
            checks++; if (lsu_ready_o !== m_lsu_acc()) begin errors++; $display("FAIL rnd_lsu_ready[%0d]: got %b expected %b", n, lsu_ready_o, m_lsu_acc()); end
            checks++; if (starve_cnt_o !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_starve[%0d]: got %0d expected %0d", n, starve_cnt_o, m_cnt); end
            checks++; if (wr_en_o !== exp_en || rd_addr_o !== exp_rd || wr_data_o !== exp_data) begin errors++; $display("FAIL rnd_port[%0d]: got en=%b rd=%0d data=%h expected en=%b rd=%0d data=%h", n, wr_en_o, rd_addr_o, wr_data_o, exp_en, exp_rd, exp_data); end
            aa = m_alu_acc();
            la = m_lsu_acc();
            tick();
        end
        reset = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 32; r++) begin
            checks++; if (rf[r] !== exp_rf[r]) begin errors++; $display("FAIL rnd_rf[x%0d]: got %h expected %h", r, rf[r], exp_rf[r]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        m_cnt = 0; exp_en = 1'b0; exp_rd = '0; exp_data = '0;
        for (int r = 0; r < 32; r++) begin
            rf[r]     = '0;
            exp_rf[r] = '0;
        end
        test_reset();
        test_alu_only();
        test_starvation();
        test_x0_mix();
        test_lsu_x0();
        test_reset_pending();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
